hlsm_shared_ctrl: RTL and testbench

//  Resource-constrained HLSM controller: computes j = a+b+c+d and l = e*f*g with ONE shared

---
 rtl/hlsm_shared_ctrl_pkg.sv | 49 ++++
 rtl/hlsm_shared_ctrl_addmul.sv | 74 +++++++
 rtl/hlsm_shared_ctrl.sv | 139 +++++++++++++
 tb/tb_hlsm_shared_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_shared_ctrl_pkg.sv
// Shared types for the resource-constrained HLSM (one adder, one multiplier).
// State encoding, default width and operand-select codes for the shared units.
package hlsm_shared_ctrl_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    FINAL = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ADD_NONE = 2'd0,
    ADD_AB   = 2'd1,
    ADD_HC   = 2'd2,
    ADD_ID   = 2'd3
  } add_sel_t;

  typedef enum logic [1:0] {
    MUL_NONE = 2'd0,
    MUL_EF   = 2'd1,
    MUL_KG   = 2'd2
  } mul_sel_t;

  function automatic add_sel_t add_sel(input state_t s);
    add_sel_t r;
    case (s)
      S1:      r = ADD_AB;
      S2:      r = ADD_HC;
      S3:      r = ADD_ID;
      default: r = ADD_NONE;
    endcase
    return r;
  endfunction

  function automatic mul_sel_t mul_sel(input state_t s);
    mul_sel_t r;
    case (s)
      S1:      r = MUL_EF;
      S2:      r = MUL_KG;
      default: r = MUL_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hlsm_shared_ctrl_addmul.sv
// Shared adder and multiplier with state-driven operand muxes.
// Purely combinational; the controller owns every register.
module hlsm_shared_ctrl_addmul
  import hlsm_shared_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DW_DEFAULT
) (
  input  logic [2:0]                  st,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  input  logic signed [DATAWIDTH-1:0] d,
  input  logic signed [DATAWIDTH-1:0] e,
  input  logic signed [DATAWIDTH-1:0] f,
  input  logic signed [DATAWIDTH-1:0] g,
  input  logic signed [DATAWIDTH-1:0] h,
  input  logic signed [DATAWIDTH-1:0] i,
  input  logic signed [DATAWIDTH-1:0] k,
  output logic signed [DATAWIDTH-1:0] sum,
  output logic signed [DATAWIDTH-1:0] prod
);

  add_sel_t asel;
  mul_sel_t msel;

  logic signed [DATAWIDTH-1:0] add_x;
  logic signed [DATAWIDTH-1:0] add_y;
  logic signed [DATAWIDTH-1:0] mul_x;
  logic signed [DATAWIDTH-1:0] mul_y;

  assign asel = add_sel(state_t'(st));
  assign msel = mul_sel(state_t'(st));

  always_comb begin
    add_x = '0;
    add_y = '0;
    unique case (1'b1)
      (asel == ADD_AB): begin
        add_x = a;
        add_y = b;
      end
      (asel == ADD_HC): begin
        add_x = h;
        add_y = c;
      end
      (asel == ADD_ID): begin
        add_x = i;
        add_y = d;
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    unique case (1'b1)
      (msel == MUL_EF): begin
        mul_x = e;
        mul_y = f;
      end
      (msel == MUL_KG): begin
        mul_x = k;
        mul_y = g;
      end
      default: ;
    endcase
  end

  // Both results keep only the low DATAWIDTH bits (wrap / truncate).
  assign sum  = add_x + add_y;
  assign prod = mul_x * mul_y;

endmodule

// File: rtl/hlsm_shared_ctrl.sv
// HLSM controller: j=a+b+c+d, l=e*f*g over WAIT,S1,S2,S3,FINAL.
// HLSM_OPERAND_LATCH_EN captures a..g when Start is accepted.
module hlsm_shared_ctrl
  import hlsm_shared_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DW_DEFAULT
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  output logic                        Done,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  input  logic signed [DATAWIDTH-1:0] d,
  input  logic signed [DATAWIDTH-1:0] e,
  input  logic signed [DATAWIDTH-1:0] f,
  input  logic signed [DATAWIDTH-1:0] g,
  output logic signed [DATAWIDTH-1:0] j,
  output logic signed [DATAWIDTH-1:0] l
);

  state_t state;

  logic signed [DATAWIDTH-1:0] h;
  logic signed [DATAWIDTH-1:0] i;
  logic signed [DATAWIDTH-1:0] k;
  logic signed [DATAWIDTH-1:0] sum;
  logic signed [DATAWIDTH-1:0] prod;

  logic signed [DATAWIDTH-1:0] oa;
  logic signed [DATAWIDTH-1:0] ob;
  logic signed [DATAWIDTH-1:0] oc;
  logic signed [DATAWIDTH-1:0] od;
  logic signed [DATAWIDTH-1:0] oe;
  logic signed [DATAWIDTH-1:0] of_;
  logic signed [DATAWIDTH-1:0] og;

`ifdef HLSM_OPERAND_LATCH_EN
  logic signed [DATAWIDTH-1:0] ra;
  logic signed [DATAWIDTH-1:0] rb;
  logic signed [DATAWIDTH-1:0] rc;
  logic signed [DATAWIDTH-1:0] rd;
  logic signed [DATAWIDTH-1:0] re;
  logic signed [DATAWIDTH-1:0] rf;
  logic signed [DATAWIDTH-1:0] rg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ra <= '0;
      rb <= '0;
      rc <= '0;
      rd <= '0;
      re <= '0;
      rf <= '0;
      rg <= '0;
    end else if (state == WAIT && Start) begin
      ra <= a;
      rb <= b;
      rc <= c;
      rd <= d;
      re <= e;
      rf <= f;
      rg <= g;
    end
  end

  assign oa  = ra;
  assign ob  = rb;
  assign oc  = rc;
  assign od  = rd;
  assign oe  = re;
  assign of_ = rf;
  assign og  = rg;
`else
  assign oa  = a;
  assign ob  = b;
  assign oc  = c;
  assign od  = d;
  assign oe  = e;
  assign of_ = f;
  assign og  = g;
`endif

  hlsm_shared_ctrl_addmul #(
    .DATAWIDTH(DATAWIDTH)
  ) u_addmul (
    .st   (state),
    .a    (oa),
    .b    (ob),
    .c    (oc),
    .d    (od),
    .e    (oe),
    .f    (of_),
    .g    (og),
    .h    (h),
    .i    (i),
    .k    (k),
    .sum  (sum),
    .prod (prod)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= WAIT;
      Done  <= 1'b0;
      h     <= '0;
      i     <= '0;
      k     <= '0;
      j     <= '0;
      l     <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        WAIT: begin
          if (Start) state <= S1;
        end
        S1: begin
          h     <= sum;
          k     <= prod;
          state <= S2;
        end
        S2: begin
          i     <= sum;
          l     <= prod;
          state <= S3;
        end
        S3: begin
          j     <= sum;
          Done  <= 1'b1;
          state <= FINAL;
        end
        FINAL: state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_shared_ctrl.sv
// Directed + randomized bench for hlsm_shared_ctrl.
// Expected results come from plain-arithmetic reference functions.
module tb_hlsm_shared_ctrl;

  localparam int DW = 16;

  logic Clk = 1'b0;
  logic Rst;
  logic Start;
  logic Done;
  logic signed [DW-1:0] a, b, c, d, e, f, g;
  logic signed [DW-1:0] j, l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  hlsm_shared_ctrl #(.DATAWIDTH(DW)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Done  (Done),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .j     (j),
    .l     (l)
  );

  function automatic logic [DW-1:0] ref_j(input int x0, x1, x2, x3);
    int s;
    s = x0 + x1 + x2 + x3;
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] ref_l(input int x0, x1, x2);
    longint p;
    p = longint'(x0) * longint'(x1) * longint'(x2);
    return DW'(p);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag,
             $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input int va, vb, vc, vd, ve, vf, vg);
    a = DW'(va);
    b = DW'(vb);
    c = DW'(vc);
    d = DW'(vd);
    e = DW'(ve);
    f = DW'(vf);
    g = DW'(vg);
  endtask

  // One run from WAIT; optionally re-pulses Start in S1, S2 and FINAL.
  task automatic run(input string tag, input logic [DW-1:0] xj,
                     input logic [DW-1:0] xl, input bit repulse);
    int extra;
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk({tag, "/done_s1"}, {15'd0, Done}, 16'd0);
    if (repulse) begin
      Start = 1'b1;
`ifdef HLSM_OPERAND_LATCH_EN
      set_ops(99, 98, 97, 96, 95, 94, 93);
`endif
    end
    step();
    chk({tag, "/done_s2"}, {15'd0, Done}, 16'd0);
    step();
    Start = 1'b0;
    chk({tag, "/done_s3"}, {15'd0, Done}, 16'd0);
    step();
    chk({tag, "/done"}, {15'd0, Done}, 16'd1);
    chk({tag, "/j"}, j, xj);
    chk({tag, "/l"}, l, xl);
    if (repulse) Start = 1'b1;
    step();
    Start = 1'b0;
    chk({tag, "/done_after"}, {15'd0, Done}, 16'd0);
    if (repulse) begin
      extra = 0;
      for (int n = 0; n < 6; n++) begin
        step();
        if (Done) extra++;
      end
      chk({tag, "/no_queued_run"}, DW'(extra), 16'd0);
    end
  endtask

  initial begin
    int va, vb, vc, vd, ve, vf, vg;
    int last_acc;
    bit rp;
    logic [DW-1:0] xj, xl;

    Rst   = 1'b1;
    Start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("reset/done_in_rst", {15'd0, Done}, 16'd0);
    step();
    chk("reset/done", {15'd0, Done}, 16'd0);
    chk("reset/j", j, 16'd0);
    chk("reset/l", l, 16'd0);
    Rst = 1'b0;
    step();

    set_ops(1, 2, 3, 4, 2, 3, 4);
    run("t1", ref_j(1, 2, 3, 4), ref_l(2, 3, 4), 1'b0);

    set_ops(32767, 1, 0, 0, 256, 256, 1);
    run("t2_wrap", ref_j(32767, 1, 0, 0), ref_l(256, 256, 1), 1'b0);

    set_ops(7, 8, 9, 10, 3, -4, 5);
    run("t3_ignore", ref_j(7, 8, 9, 10), ref_l(3, -4, 5), 1'b1);

    // Reset in S2 kills the run and clears results.
    set_ops(1, 2, 3, 4, 2, 3, 4);
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("t4_rst/done", {15'd0, Done}, 16'd0);
    chk("t4_rst/j", j, 16'd0);
    chk("t4_rst/l", l, 16'd0);
    step();
    chk("t4_rst/idle", {15'd0, Done}, 16'd0);
    set_ops(1, 2, 3, 4, 5, 6, 7);
    run("t4_fresh", ref_j(1, 2, 3, 4), ref_l(5, 6, 7), 1'b0);

    // Start held high: accepts every 5 edges, Done 3 edges after accept.
    set_ops(-5, -5, -5, -5, -2, 3, -1);
    xj = ref_j(-5, -5, -5, -5);
    xl = ref_l(-2, 3, -1);
    Start = 1'b1;
    last_acc = -100;
    for (int ed = 0; ed < 24; ed++) begin
      if (ed == 20) Start = 1'b0;
      step();
      if (ed < 20 && ed >= last_acc + 5) last_acc = ed;
      chk($sformatf("t5/done_e%0d", ed), {15'd0, Done},
          {15'd0, (ed == last_acc + 3)});
      if (ed == last_acc + 3) begin
        chk($sformatf("t5/j_e%0d", ed), j, xj);
        chk($sformatf("t5/l_e%0d", ed), l, xl);
      end
    end

    // Operands dropped to 0 right after accept.
    set_ops(1, 2, 3, 4, 2, 3, 4);
    Start = 1'b1;
    step();
    Start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
    chk("t6/done", {15'd0, Done}, 16'd1);
`ifdef HLSM_OPERAND_LATCH_EN
    chk("t6/j", j, ref_j(1, 2, 3, 4));
    chk("t6/l", l, ref_l(2, 3, 4));
`else
    chk("t6/j", j, ref_j(0, 0, 0, 0));
    chk("t6/l", l, ref_l(0, 0, 0));
`endif
    step();

    for (int it = 0; it < 12; it++) begin
      va = int'($signed(16'($urandom_range(0, 65535))));
      vb = int'($signed(16'($urandom_range(0, 65535))));
      vc = int'($signed(16'($urandom_range(0, 65535))));
      vd = int'($signed(16'($urandom_range(0, 65535))));
      ve = int'($signed(16'($urandom_range(0, 65535))));
      vf = int'($signed(16'($urandom_range(0, 65535))));
      vg = int'($signed(16'($urandom_range(0, 65535))));
      rp = 1'($urandom_range(0, 1));
      for (int gap = $urandom_range(0, 3); gap > 0; gap--) step();
      set_ops(va, vb, vc, vd, ve, vf, vg);
      run($sformatf("rnd%0d", it), ref_j(va, vb, vc, vd),
          ref_l(ve, vf, vg), rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
